// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the cache/memory datapath blocks.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_chunk;

   typedef enum bit [1:0] {ARB_IDLE, ARB_I, ARB_D} lc3b_arb_state;

   localparam bit GRANT_I = 1'b0;
   localparam bit GRANT_D = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares one memory line port between the I-cache and D-cache: one owner per
// transaction, command latched at grant, completion routed to the owner only.
module cache_mem_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              m_read,
   output logic              m_write,
   output logic [ADDR_W-1:0] m_address,
   output logic [LINE_W-1:0] m_wdata,
   input  logic [LINE_W-1:0] m_rdata,
   input  logic              m_resp
);

   lc3b_arb_state     state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              d_req;
   logic              granted;

   // Under contention the requester that was not served last wins.
   function automatic lc3b_arb_state arb_pick(input logic i_req, input logic d_rq,
                                              input logic last_d);
      if (i_req && d_rq) return last_d ? ARB_I : ARB_D;
      else if (d_rq)     return ARB_D;
      else if (i_req)    return ARB_I;
      else               return ARB_IDLE;
   endfunction

   assign d_req = d_read | d_write;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      i_resp       = 1'b0;
      d_resp       = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            state_d = arb_pick(i_read, d_req, last_grant_q);
            if (state_d == ARB_I) begin
               addr_d       = i_address;
               wdata_d      = '0;
               rd_d         = 1'b1;
               wr_d         = 1'b0;
               last_grant_d = GRANT_I;
            end else if (state_d == ARB_D) begin
               // A simultaneous read+write is illegal; the writeback takes it.
               addr_d       = d_address;
               wdata_d      = d_wdata;
               rd_d         = ~d_write;
               wr_d         = d_write;
               last_grant_d = GRANT_D;
            end
         end
         ARB_I: begin
            if (m_resp) begin
               i_resp  = 1'b1;
               state_d = ARB_IDLE;
            end
         end
         ARB_D: begin
            if (m_resp) begin
               d_resp  = 1'b1;
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         last_grant_q <= GRANT_I;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
      end
   end

   // Latched address/data are only visible while granted, so they need no reset.
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
   end

   assign granted   = (state_q != ARB_IDLE);
   assign m_read    = granted & rd_q;
   assign m_write   = granted & wr_q;
   assign m_address = granted ? addr_q  : '0;
   assign m_wdata   = granted ? wdata_q : '0;
   assign i_rdata   = m_rdata;
   assign d_rdata   = m_rdata;

   a_no_d_read_write: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level reference model.
module tb_cache_mem_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_read;
   logic [15:0]  i_address;
   logic [127:0] i_rdata;
   logic         i_resp;
   logic         d_read, d_write;
   logic [15:0]  d_address;
   logic [127:0] d_wdata;
   logic [127:0] d_rdata;
   logic         d_resp;
   logic         m_read, m_write;
   logic [15:0]  m_address;
   logic [127:0] m_wdata;
   logic [127:0] m_rdata;
   logic         m_resp;

   int errors = 0;
   int checks = 0;

   // Reference model: who owns the memory port and what it asked for.
   int           owner = 0;       // 0 = nobody, 1 = I-cache, 2 = D-cache
   bit           d_served_last = 0;
   logic [15:0]  own_addr = '0;
   logic [127:0] own_wdata = '0;
   bit           own_rd = 0, own_wr = 0;

   always #5 clk = ~clk;

   cache_mem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_resp(m_resp)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Mid-cycle: compare every output with what the model predicts.
   task automatic at_neg();
      @(negedge clk);
      chk("m_read",    m_read,    (owner != 0) && own_rd);
      chk("m_write",   m_write,   (owner != 0) && own_wr);
      chk("m_address", m_address, (owner != 0) ? own_addr  : 16'h0);
      chk("m_wdata",   m_wdata,   (owner != 0) ? own_wdata : 128'h0);
      chk("i_resp",    i_resp,    (owner == 1) && m_resp);
      chk("d_resp",    d_resp,    (owner == 2) && m_resp);
      chk("i_rdata",   i_rdata,   m_rdata);
      chk("d_rdata",   d_rdata,   m_rdata);
   endtask

   // Clock edge: advance the model with the inputs as sampled by the DUT.
   task automatic tick();
      bit want_i, want_d, give_d;
      @(posedge clk);
      want_i = i_read;
      want_d = d_read || d_write;
      if (rst) begin
         owner = 0;
         d_served_last = 0;
      end else if (owner != 0) begin
         if (m_resp) owner = 0;
      end else if (want_i || want_d) begin
         give_d = want_d && (!want_i || !d_served_last);
         if (give_d) begin
            owner = 2; own_addr = d_address; own_wdata = d_wdata;
            own_wr = d_write; own_rd = !d_write;
         end else begin
            owner = 1; own_addr = i_address; own_wdata = '0;
            own_wr = 0; own_rd = 1;
         end
         d_served_last = give_d;
      end
      #1;
   endtask

   task automatic cyc();
      at_neg();
      tick();
   endtask

   initial begin
      logic [15:0] exp_addr;
      rst = 1; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
      d_address = '0; d_wdata = '0; m_rdata = '0; m_resp = 0;
      @(posedge clk); #1;
      tick();
      cyc();
      rst = 0;
      at_neg();
      chk("reset_m_read", m_read, 1'b0);
      chk("reset_m_write", m_write, 1'b0);
      chk("reset_m_address", m_address, 16'h0);
      tick();

      // I-cache alone; request dropped and address changed while waiting.
      i_read = 1; i_address = 16'h1230;
      cyc();
      i_read = 0; i_address = 16'hFFFE;
      at_neg();
      chk("i_grant_m_read", m_read, 1'b1);
      chk("i_grant_addr", m_address, 16'h1230);
      tick();
      cyc(); cyc();
      at_neg();
      chk("i_hold_addr", m_address, 16'h1230);
      tick();
      m_resp = 1; m_rdata = {16{8'hA5}};
      at_neg();
      chk("i_resp_pulse", i_resp, 1'b1);
      chk("i_rdata_line", i_rdata, {16{8'hA5}});
      chk("i_other_resp", d_resp, 1'b0);
      tick();
      m_resp = 0;
      at_neg();
      chk("i_done_m_read", m_read, 1'b0);
      tick();

      // D-cache writeback.
      d_write = 1; d_address = 16'h4460; d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
      cyc();
      d_write = 0;
      for (int k = 0; k < 2; k++) begin
         at_neg();
         chk("d_wb_m_write", m_write, 1'b1);
         chk("d_wb_m_wdata", m_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
         tick();
      end
      m_resp = 1;
      at_neg();
      chk("d_wb_resp", d_resp, 1'b1);
      tick();
      m_resp = 0;
      at_neg();
      chk("d_wb_resp_once", d_resp, 1'b0);
      tick();

      // Contention straight after reset: D, I, D, I.
      rst = 1; cyc(); rst = 0;
      i_read = 1; i_address = 16'h1000; d_read = 1; d_address = 16'h2000;
      for (int t = 0; t < 4; t++) begin
         cyc();
         exp_addr = (t % 2 == 0) ? 16'h2000 : 16'h1000;
         at_neg();
         chk("contend_owner_addr", m_address, exp_addr);
         tick();
         cyc();
         m_resp = 1;
         cyc();
         m_resp = 0;
      end
      i_read = 0; d_read = 0;
      cyc();

      // Reset while D owns the port, with m_resp in the same cycle.
      d_write = 1; d_address = 16'h4460;
      cyc();
      d_write = 0;
      cyc();
      rst = 1; m_resp = 1;
      cyc();
      rst = 0; m_resp = 0;
      at_neg();
      chk("rst_mid_m_write", m_write, 1'b0);
      chk("rst_mid_d_resp", d_resp, 1'b0);
      tick();
      m_resp = 1;
      at_neg();
      chk("stray_d_resp", d_resp, 1'b0);
      chk("stray_i_resp", i_resp, 1'b0);
      tick();
      m_resp = 0;
      at_neg();
      chk("stray_stays_idle", m_read | m_write, 1'b0);
      tick();

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         rst       = ($urandom_range(0, 63) == 0);
         i_read    = $urandom_range(0, 1);
         i_address = 16'($urandom);
         case ($urandom_range(0, 2))
            0: begin d_read = 0; d_write = 0; end
            1: begin d_read = 1; d_write = 0; end
            default: begin d_read = 0; d_write = 1; end
         endcase
         d_address = 16'($urandom);
         d_wdata   = {$urandom, $urandom, $urandom, $urandom};
         m_rdata   = {$urandom, $urandom, $urandom, $urandom};
         m_resp    = ($urandom_range(0, 3) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the single physical-memory (or L2) line port between the instruction cache and the data cache of the pipelined LC-3b core. It grants one requester at a time and latches that requester's address, write data and command for the duration of the transaction. Completion is routed back to the winner only. The block sits between the two L1 cache controllers and the memory port; lines are `lc3b_chunk` (128 bits).

## Interface
Parameters:
- `ADDR_W`, 16: byte address width (`lc3b_word`)
- `LINE_W`, 128: line width (`lc3b_chunk`)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_read`  in  1  I-cache line read request
- `i_address`  in  ADDR_W  I-cache line address
- `i_rdata`  out  LINE_W  line returned to I-cache
- `i_resp`  out  1  I-cache transaction complete, 1-cycle pulse
- `d_read`, `d_write`  in  1 each  D-cache read / writeback request
- `d_address`  in  ADDR_W  D-cache line address
- `d_wdata`  in  LINE_W  D-cache writeback line
- `d_rdata`  out  LINE_W  line returned to D-cache
- `d_resp`  out  1  D-cache transaction complete, 1-cycle pulse
- `m_read`, `m_write`  out  1 each  memory command
- `m_address`  out  ADDR_W  memory address
- `m_wdata`  out  LINE_W  memory write line
- `m_rdata`  in  LINE_W  memory read line
- `m_resp`  in  1  memory completion pulse

## Operation
- FSM states, in package enum `lc3b_arb_state`:
  - `ARB_IDLE`
  - `ARB_I`: I-cache granted
  - `ARB_D`: D-cache granted
- Additional state: `last_grant` (1 bit, 0 = I, 1 = D), plus latched `addr_q`, `wdata_q`, `rd_q`, `wr_q`.
- `ARB_IDLE` grant decision:
  - Only the I-cache requesting (`i_read`): go to `ARB_I`.
  - Only the D-cache requesting (`d_read|d_write`): go to `ARB_D`.
  - Both requesting: D wins unless `last_grant` = D, in which case I wins. Contention therefore alternates and neither requester starves.
  - On the grant edge: latch the winner's address, data and command, and update `last_grant`.
- Granted state:
  - `m_read` = `rd_q`, `m_write` = `wr_q`, `m_address` = `addr_q`, `m_wdata` = `wdata_q`.
  - Requester inputs are ignored after latching; a requester dropping its request mid-transaction does not abort the transaction.
- Completion:
  - On `m_resp` in a granted state, the winner's `*_resp` = 1 combinationally in the same cycle, and its `*_rdata` = `m_rdata`.
  - The next state is `ARB_IDLE`.
  - The other requester's resp stays 0.
- `m_resp` in `ARB_IDLE` is ignored; no resp is issued.
- `d_read` and `d_write` both high at grant: `wr_q` = 1, `rd_q` = 0 (write wins). This input combination is illegal; an assertion flags it.
- `i_rdata` and `d_rdata` are driven with `m_rdata` at all times; they are qualified only by resp.

## Timing
- Reset values:
  - State = `ARB_IDLE`, `last_grant` = I (so D wins the first contention).
  - `m_read`, `m_write`, `i_resp`, `d_resp` = 0.
  - `m_address`, `m_wdata` = 0.
- Grant latency: a request sampled in `ARB_IDLE` at cycle N gives `m_read`/`m_write` high from cycle N+1.
- `m_resp` at cycle K gives resp at cycle K, and `m_read`/`m_write` low at K+1 (state `ARB_IDLE`).
- A new request present at K+1 is granted at K+2. Minimum back-to-back spacing is therefore 1 idle cycle.
- Memory commands are held constant, all bits stable, from grant until the `m_resp` cycle inclusive.
- Reset mid-transaction: all outputs return to reset values next cycle; a late `m_resp` is ignored.

## Structure
- Add to the shared package `lc3b_types`:
  - `typedef enum bit [1:0] {ARB_IDLE, ARB_I, ARB_D} lc3b_arb_state;`
  - Reuse `lc3b_word` and `lc3b_chunk`.
- One module. The FSM plus latch register is about 150–200 lines of RTL.
- No sub-module is required; the grant-priority function may be a local function `arb_pick`.

## Test plan
- I only: `i_read`=1, `i_address`=0x1230 at cycle 0 → `m_read`=1, `m_address`=0x1230 from cycle 1. Memory `m_resp` at cycle 5 with `m_rdata`=0xA5..A5 → `i_resp`=1 and `i_rdata`=0xA5..A5 at cycle 5, `d_resp`=0, `m_read`=0 at cycle 6.
- D writeback: `d_write`=1, `d_address`=0x4460, `d_wdata`=0x0123..EF → `m_write`=1 with that address/data until `m_resp`, then `d_resp` pulse for exactly 1 cycle.
- Contention after reset: `i_read`, `d_read` both asserted at cycle 0 → D granted first. I is granted in the cycle after D's resp + 1. Repeating both requests alternates D, I, D, I.
- Stability: change `i_address` to 0xFFFE while `ARB_I` is waiting → `m_address` stays 0x1230 until `m_resp`.
- Reset mid-op: assert `rst` while in `ARB_D` with `m_resp` arriving the same cycle → `m_write`=0, `d_resp`=0 after reset. A subsequent `m_resp` in IDLE produces no resp.
- Stray `m_resp` in `ARB_IDLE` with no requests → `i_resp`=`d_resp`=0, state stays `ARB_IDLE`.
